// File: rtl/fpnew_sdotp_lane_sequencer.sv
// Feeds one wide SDOTP/VSUM request through a single SliceWidth-bit sdotp unit slice by slice.
// Optional partial-slice mode is enabled by defining FPNEW_SDOTP_SEQ_PARTIAL_EN.
module fpnew_sdotp_lane_sequencer #(
    parameter int unsigned LaneWidth      = 128,
    parameter int unsigned SliceWidth     = 64,
    parameter int unsigned TagWidth       = 4,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned NumSlices     = LaneWidth / SliceWidth,
    localparam int unsigned CntW          = $clog2(NumSlices + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [2:0][LaneWidth-1:0]  operands_i,
    input  logic [TagWidth-1:0]        tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
    input  logic [CntW-1:0]            num_slices_i,
`endif
    output logic [2:0][SliceWidth-1:0] unit_operands_o,
    output logic                       unit_valid_o,
    input  logic                       unit_ready_i,
    input  logic [SliceWidth-1:0]      unit_result_i,
    input  logic [4:0]                 unit_status_i,
    input  logic                       unit_valid_i,
    output logic                       unit_ready_o,
    output logic [LaneWidth-1:0]       result_o,
    output logic [4:0]                 status_o,
    output logic [TagWidth-1:0]        tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);

    localparam int unsigned    IdxW       = (NumSlices > 1) ? $clog2(NumSlices) : 1;
    localparam int unsigned    DrainW     = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] NumSlicesC = CntW'(NumSlices);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                                  r_state;
    state_e                                  w_state_next;
    logic [2:0][NumSlices-1:0][SliceWidth-1:0] r_operands;
    logic [NumSlices-1:0][SliceWidth-1:0]    r_result;
    logic [4:0]                              r_status;
    logic [TagWidth-1:0]                     r_tag;
    logic [CntW-1:0]                         r_issue_cnt;
    logic [CntW-1:0]                         r_collect_cnt;
    logic [DrainW-1:0]                       r_drain_cnt;
    logic [DrainW-1:0]                       w_drain_load;
    logic [CntW-1:0]                         w_outstanding;
    logic [CntW-1:0]                         w_num_slices;
    logic [IdxW-1:0]                         w_issue_idx;
    logic [IdxW-1:0]                         w_collect_idx;
    logic                                    w_in_fire;
    logic                                    w_issue_fire;
    logic                                    w_ret_fire;

`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
    logic [CntW-1:0] r_num_slices;
    logic [CntW-1:0] w_num_req;
    // Zero selects the full lane; oversized requests are clamped to the lane.
    assign w_num_req    = (num_slices_i == '0 || num_slices_i > NumSlicesC) ? NumSlicesC
                                                                            : num_slices_i;
    assign w_num_slices = r_num_slices;
`else
    assign w_num_slices = NumSlicesC;
`endif

    assign w_outstanding = r_issue_cnt - r_collect_cnt;
    // Counters run one past the last slot; clip so the index never leaves the array.
    assign w_issue_idx   = (r_issue_cnt < NumSlicesC) ? r_issue_cnt[IdxW-1:0] : '0;
    assign w_collect_idx = (r_collect_cnt < NumSlicesC) ? r_collect_cnt[IdxW-1:0] : '0;
    assign w_in_fire     = in_valid_i && in_ready_o;
    assign w_issue_fire  = unit_valid_o && unit_ready_i;
    assign w_ret_fire    = unit_valid_i && unit_ready_o;
    assign w_drain_load  = DrainW'(w_outstanding) + DrainW'(w_issue_fire) - DrainW'(w_ret_fire);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_in_fire) w_state_next = ST_RUN;
            ST_RUN: begin
                if (flush_i)                            w_state_next = ST_IDLE;
                else if (r_collect_cnt == w_num_slices) w_state_next = ST_DONE;
            end
            ST_DONE: if (flush_i || out_ready_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o   = 1'b0;
        unit_valid_o = 1'b0;
        unit_ready_o = 1'b0;
        out_valid_o  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            unit_operands_o[k] = r_operands[k][w_issue_idx];
        end
        case (r_state)
            ST_IDLE: begin
                in_ready_o   = (r_drain_cnt == '0);
                unit_ready_o = (r_drain_cnt != '0);
            end
            ST_RUN: begin
                unit_valid_o = (r_issue_cnt < w_num_slices)
                            && (32'(w_outstanding) < MaxOutstanding);
                unit_ready_o = (w_outstanding != '0);
            end
            ST_DONE: out_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o   = (r_state != ST_IDLE) || (r_drain_cnt != '0);
    assign result_o = r_result;
    assign status_o = r_status;
    assign tag_o    = r_tag;

    // NOTE: the result buffer is a storage array but is cleared on reset because result_o must read 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_operands    <= '0;
            r_result      <= '0;
            r_status      <= '0;
            r_tag         <= '0;
            r_issue_cnt   <= '0;
            r_collect_cnt <= '0;
            r_drain_cnt   <= '0;
`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
            r_num_slices  <= NumSlicesC;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_operands    <= operands_i;
                        r_tag         <= tag_i;
                        r_status      <= '0;
                        r_issue_cnt   <= '0;
                        r_collect_cnt <= '0;
`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
                        r_num_slices  <= w_num_req;
                        r_result      <= '1;
`endif
                    end
                    if (w_ret_fire) r_drain_cnt <= r_drain_cnt - 1'b1;
                end
                ST_RUN: begin
                    if (flush_i) begin
                        r_drain_cnt <= w_drain_load;
                    end else begin
                        if (w_issue_fire) r_issue_cnt <= r_issue_cnt + 1'b1;
                        if (w_ret_fire) begin
                            r_result[w_collect_idx] <= unit_result_i;
                            r_status                <= r_status | unit_status_i;
                            r_collect_cnt           <= r_collect_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpnew_sdotp_lane_sequencer.sv
// Directed bench for fpnew_sdotp_lane_sequencer with a small in-order sdotp unit model.
// Exercises the partial-slice path too when FPNEW_SDOTP_SEQ_PARTIAL_EN is defined.
module tb_fpnew_sdotp_lane_sequencer;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0][127:0] operands;
    logic [3:0]       tag_in;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [2:0][63:0] unit_ops;
    logic             unit_valid_o;
    logic             unit_ready_i;
    logic [63:0]      unit_result;
    logic [4:0]       unit_status;
    logic             unit_valid_i;
    logic             unit_ready_o;
    logic [127:0]     result;
    logic [4:0]       status;
    logic [3:0]       tag_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [1:0]       num_slices;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 2;
    int n_issued = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  st;
        int          due;
    } rsp_t;
    rsp_t rsp_q[$];

    fpnew_sdotp_lane_sequencer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .operands_i      (operands),
        .tag_i           (tag_in),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .flush_i         (flush),
`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
        .num_slices_i    (num_slices),
`endif
        .unit_operands_o (unit_ops),
        .unit_valid_o    (unit_valid_o),
        .unit_ready_i    (unit_ready_i),
        .unit_result_i   (unit_result),
        .unit_status_i   (unit_status),
        .unit_valid_i    (unit_valid_i),
        .unit_ready_o    (unit_ready_o),
        .result_o        (result),
        .status_o        (status),
        .tag_o           (tag_out),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Unit model: result = a_slice - 1, status = b_slice[4:0], returned lat cycles after issue.
    initial begin : unit_model
        unit_valid_i = 1'b0;
        unit_result  = '0;
        unit_status  = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                rsp_q.delete();
                unit_valid_i = 1'b0;
            end else begin
                if (unit_valid_i && unit_ready_o) void'(rsp_q.pop_front());
                if (unit_valid_o && unit_ready_i) begin
                    rsp_q.push_back('{unit_ops[0] - 64'd1, unit_ops[1][4:0], cyc + lat});
                    n_issued++;
                end
                cyc++;
                #1;
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    unit_valid_i = 1'b1;
                    unit_result  = rsp_q[0].data;
                    unit_status  = rsp_q[0].st;
                end else begin
                    unit_valid_i = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] a, input logic [127:0] b, input logic [3:0] t,
                        output int waited);
        operands[0] = a;
        operands[1] = b;
        operands[2] = 128'h0;
        tag_in      = t;
        in_valid    = 1'b1;
        waited      = 0;
        while (!in_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check(tag, 0, 1);
    endtask

    task automatic pop_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("after_pop", {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        int n;
        int i0;
        rst_n        = 1'b0;
        operands     = '0;
        tag_in       = '0;
        in_valid     = 1'b0;
        flush        = 1'b0;
        unit_ready_i = 1'b1;
        out_ready    = 1'b0;
        num_slices   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {in_ready, out_valid, unit_valid_o, unit_ready_o, busy}, 5'b10000);
        check("rst_data", {result, status, tag_out}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic: two slices, latency 2, result = slice index.
        i0 = n_issued;
        send({64'h2, 64'h1}, '0, 4'h3, n);
        check("run_in_ready", {in_ready, busy}, 2'b01);
        wait_out("basic_timeout", n);
        check("basic_latency", n, 5);
        check("basic_result", result, {64'h1, 64'h0});
        check("basic_status_tag", {status, tag_out}, {5'b00000, 4'h3});
        check("basic_issues", n_issued - i0, 2);
        pop_out();

        // Status OR-merge across slices.
        send({64'h2, 64'h1}, {64'h10, 64'h01}, 4'hA, n);
        wait_out("status_timeout", n);
        check("status_merge", {status, tag_out}, {5'b10001, 4'hA});
        pop_out();

        // Unit back-pressure on slice 1, then downstream back-pressure in DONE.
        i0 = n_issued;
        send({64'h7, 64'h4}, '0, 4'h5, n);
        @(posedge clk); #1;
        unit_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_op", {unit_valid_o, unit_ops[0]}, {1'b1, 64'h7});
            @(posedge clk); #1;
        end
        unit_ready_i = 1'b1;
        wait_out("stall_timeout", n);
        check("stall_issues", n_issued - i0, 2);
        for (int i = 0; i < 4; i++) begin
            check("done_hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 64'h6, 64'h3});
            @(posedge clk); #1;
        end
        pop_out();

        // Flush after two issues with none returned; stale results must be drained.
        lat = 6;
        i0  = n_issued;
        send({64'h9, 64'h8}, '0, 4'h2, n);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush_pre_issues", n_issued - i0, 2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ctrl", {out_valid, unit_valid_o, in_ready, busy, unit_ready_o}, 5'b00011);
        check("flush_drain", dut.r_drain_cnt, 2);
        lat = 2;
        send({64'h30, 64'h20}, '0, 4'h6, n);
        check("drain_wait", n, 5);
        wait_out("post_flush_timeout", n);
        check("post_flush_result", {result, tag_out}, {64'h2f, 64'h1f, 4'h6});
        pop_out();

        // Asynchronous reset in RUN.
        send({64'h2, 64'h1}, '0, 4'h1, n);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {in_ready, out_valid, unit_valid_o, unit_ready_o, busy}, 5'b10000);
        check("mid_rst_data", {result, status, tag_out}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst", {in_ready, busy, out_valid}, 3'b100);

`ifdef FPNEW_SDOTP_SEQ_PARTIAL_EN
        // Partial: one slice only, upper slot NaN-boxed.
        num_slices = 2'd1;
        i0 = n_issued;
        send({64'h5, 64'h9}, {64'h1f, 64'h0}, 4'h7, n);
        num_slices = 2'd0;
        wait_out("partial_timeout", n);
        check("partial_result", {result, status}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 5'b00000});
        check("partial_issues", n_issued - i0, 1);
        pop_out();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpnew_sdotp_lane_sequencer.md
Name: fpnew_sdotp_lane_sequencer

Overview:
Time-multiplexes one wide SDOTP/VSUM request (LaneWidth bits per operand) onto a single SliceWidth-bit sdotp datapath.
- Issues NumSlices slices back to back and collects the in-order slice results into a reassembly buffer.
- Returns the full-width result with status flags OR-merged across slices.
- Sits between the FPU lane dispatcher and one fpnew_sdotp_multi wrapper instance, so wide vectors are supported without replicating the datapath.

Parameters:
- LaneWidth, 128, width of the wide operands and result; must be a multiple of SliceWidth.
- SliceWidth, 64, operand/result width of the attached sdotp unit.
- TagWidth, 4, width of the opaque tag carried with each request.
- MaxOutstanding, 4, maximum unit responses in flight (bounds the drain counter); must be ≥ 1.
- NumSlices (localparam), LaneWidth/SliceWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- operands_i  in  3xLaneWidth  wide operands a, b, c
- tag_i  in  TagWidth  request tag
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request ready
- flush_i  in  1  synchronous flush/kill
- unit_operands_o  out  3xSliceWidth  slice operands to unit
- unit_valid_o  out  1  slice issue valid
- unit_ready_i  in  1  unit accepts slice
- unit_result_i  in  SliceWidth  slice result
- unit_status_i  in  5  slice status {NV,DZ,OF,UF,NX}
- unit_valid_i  in  1  slice result valid
- unit_ready_o  out  1  sequencer accepts slice result
- result_o  out  LaneWidth  assembled result
- status_o  out  5  OR of all slice statuses
- tag_o  out  TagWidth  tag of completed request
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- busy_o  out  1  any request, slice or drain pending

Behaviour:
- Clocking: one clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=IDLE; all counters 0; result buffer 0; status 0; tag 0. Outputs: in_ready_o=1, out_valid_o=0, unit_valid_o=0, unit_ready_o=0, busy_o=0.
- Reset mid-operation: discards everything immediately; no output handshake completes.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready_o = (drain_cnt==0).
  - On in_valid_i&&in_ready_o: latch operands and tag, clear status, issue_cnt=collect_cnt=0, go to RUN.
- RUN:
  - unit_valid_o = (issue_cnt<NumSlices) && (issue_cnt-collect_cnt<MaxOutstanding).
  - unit_operands_o[k] = latched operand k bits [issue_cnt*SliceWidth +: SliceWidth].
  - issue_cnt increments on unit_valid_o&&unit_ready_i.
  - unit_ready_o=1. On unit_valid_i: write unit_result_i to slot collect_cnt, OR unit_status_i into status, increment collect_cnt.
  - Results are assumed in issue order.
  - Issue and return in the same cycle are both performed.
  - When the final slice result is accepted, go to DONE on the next cycle.
- DONE:
  - out_valid_o=1; result_o, status_o and tag_o are held stable.
  - On out_ready_i go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency: with a unit of latency L that is always ready, first result_o is valid L+NumSlices+1 cycles after input acceptance.
- Flush (flush_i=1):
  - Next state is IDLE; out_valid_o and unit_valid_o drop next cycle.
  - drain_cnt is loaded with issue_cnt-collect_cnt, counting any return in the flush cycle.
  - While drain_cnt>0: unit_ready_o=1, returned results are discarded and decrement drain_cnt, in_ready_o=0.
  - flush_i in IDLE with drain_cnt==0 has no effect.
- Unit results arriving with nothing outstanding are never accepted (unit_ready_o=0).
- busy_o = (state!=IDLE) || (drain_cnt!=0).
- NumSlices=1 is legal: one issue, one collect.

Optional Feature:
- Macro: FPNEW_SDOTP_SEQ_PARTIAL_EN.
- Defined:
  - Adds input num_slices_i, width $clog2(NumSlices+1), latched on acceptance; 0 means NumSlices.
  - Only the first num_slices_i slices are issued and collected.
  - Remaining result slots are forced to all-ones (NaN-boxed) and contribute no status.
- Undefined: port absent; all NumSlices slices are always processed.

Test Plan:
- Default params, a=0x...0002_..._0001, unit model returns slice index with latency 2, always ready → result_o={64'h1,64'h0}, out_valid_o 5 cycles after acceptance, status_o=0.
- Slice 0 status 5'b00001, slice 1 status 5'b10000 → status_o=5'b10001, tag_o equals tag_i (4'hA).
- unit_ready_i low 3 cycles on slice 1, out_ready_i low 4 cycles in DONE → unit_operands_o and result_o held stable, no duplicate issue, in_ready_o stays 0.
- flush_i after 2 issues with 0 returned → IDLE next cycle, drain_cnt=2, in_ready_o=0 until both stale results return, next request's result uncorrupted.
- Reset asserted in RUN → all outputs at reset values asynchronously, in_ready_o=1 after release.
- PARTIAL_EN, LaneWidth=256, num_slices_i=1 → exactly 1 issue, result_o[255:64] all-ones.
